move_history: RTL
=================

# move_history

Move-history stack and undo sequencer for the cube-solver datapath. Records every rotation the control unit sends to `alu` (RTX0, RTX2, RTY0, RTY2, RTZ0, RTZ2, encodings from `def.h`). On request it replays the inverse rotations in LIFO order as `alu` op codes, which lets the depth-first search backtrack one move or rewind to the start state. It sits beside the control unit: it watches the op bus on the way in and drives an undo op stream back into the op mux.

## Interface
- `DEPTH`, 16: maximum recorded moves; must be a power of two, at least 2.
- `OPW`, 4: op code width; matches `alu` `op`.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `push`  in  1  the op on `op_in` was issued to `alu` this cycle.
- `op_in`  in  OPW  issued op code.
- `undo_req`  in  1  level request: undo one move.
- `rewind_req`  in  1  level request: undo all moves.
- `clr_err`  in  1  clears the sticky error flags.
- `req_ack`  out  1  one-cycle pulse when a request is accepted.
- `out_valid`  out  1  `out_op` holds an inverse rotation.
- `out_ready`  in  1  consumer accepts `out_op`.
- `out_op`  out  OPW  inverse rotation op code.
- `done`  out  1  one-cycle pulse when an undo or rewind completes.
- `count`  out  $clog2(DEPTH)+1  number of stored moves.
- `full`, `empty`  out  1  `count==DEPTH` and `count==0`.
- `last_op`  out  OPW  the forward op most recently recorded (top of stack); 0 when empty.
- `ovf`, `unf`  out  1  sticky overflow and underflow flags.

## Operation
- Inverse map is fixed:
  - RTX0↔RTX2
  - RTY0↔RTY2
  - RTZ0↔RTZ2
- Each entry stores the inverse op. `last_op` is the inverse of the stored inverse.
- `push` is honoured only in IDLE and only for the six rotation codes. All other ops (INC, DEC, COMP, CHECK, LOAD, STORE, D_ADD, …) are ignored silently.
- A rotation push while `full`: the entry is dropped, `ovf` is set, `count` is unchanged.
- FSM states: IDLE, UNDO, REWIND.
  - IDLE: `push` has priority. `undo_req` or `rewind_req` is accepted only when `push` is low. If both requests are high, `rewind_req` wins.
  - IDLE with `undo_req` accepted and `empty`: set `unf`, pulse `req_ack`, stay in IDLE, no `done`.
  - IDLE with `undo_req` accepted and not `empty`: pulse `req_ack`, go to UNDO.
  - IDLE with `rewind_req` accepted and `empty`: pulse `req_ack` and `done` in the same cycle, stay in IDLE.
  - IDLE with `rewind_req` accepted and not `empty`: pulse `req_ack`, go to REWIND.
  - UNDO: `out_valid` high, `out_op` = top entry. On `out_valid&&out_ready`: pop, pulse `done`, go to IDLE.
  - REWIND: emit the top entry, pop on each handshake. When the pop empties the stack, pulse `done` and go to IDLE.
- `out_op` stays stable while `out_valid && !out_ready`.
- `push` in UNDO or REWIND is ignored. It is not recorded and no flag is set.
- `clr_err` clears `ovf` and `unf` on the next edge. If an error event occurs in the same cycle, the set wins.
- Storage is a register array with a pointer. `count` saturates at 0 and DEPTH; it never wraps.

## Timing
- Reset values:
  - state IDLE, `count`=0, `empty`=1, `full`=0
  - `out_valid`=0, `out_op`=0, `last_op`=0
  - `req_ack`=0, `done`=0, `ovf`=0, `unf`=0
- Reset mid-REWIND aborts the rewind and empties the stack.
- Push: `count`, `last_op`, `full` and `empty` update on the edge that samples `push`.
- `req_ack` is registered: it goes high the cycle after the accepting edge, together with the state change.
- `out_valid` rises in that same cycle.
- Each pop takes effect on the handshake edge. In REWIND the next `out_op` is valid the following cycle, so the rate is 1 move/cycle with `out_ready` held high.
- `done` is registered: it is high for the single cycle after the final handshake edge, with the state already back in IDLE.
- A rewind of N moves with `out_ready`=1 takes 1 accept cycle + N emit cycles; `done` follows.

## Test plan
- Reset, then push RTX0, RTY2, RTZ0 → `count`=3, `last_op`=RTZ0. Rewind with `out_ready`=1 → `out_op` = RTZ2, RTY0, RTX2 on three consecutive cycles, then `done`, `empty`=1.
- Push INC, LOAD, D_ADD, RTX2 → `count`=1, `last_op`=RTX2. `undo_req` → `out_op`=RTX0, one handshake, `done`, `count`=0.
- `undo_req` on empty → `req_ack`, `unf`=1, no `out_valid`. `clr_err` → `unf`=0 next cycle.
- With DEPTH=16, push 17 rotations → `full`=1, `ovf`=1, `count`=16. The 17th is not stored: rewind emits exactly 16 ops.
- UNDO with `out_ready` held low for 5 cycles → `out_op` stable, `count` unchanged. Raise `out_ready` → one pop, `done`. A `push` asserted during the stall is not recorded.
- `push` and `undo_req` high together in IDLE → the push is recorded, then the undo is accepted next cycle and emits the inverse of that push. Assert `rst` mid-rewind → all outputs take their reset values immediately.

Source files
------------

// File: rtl/move_history.sv
// -----------------------------------------------------------------------------
// move_history
//
// Move-history stack and undo sequencer for the cube-solver datapath.
// Watches the op bus towards `alu`, records every rotation issued in IDLE
// (stored as its inverse), and on request replays the stored inverses in
// LIFO order so the search can back out one move (undo) or all moves
// (rewind).
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   push, op_in   : op issued to alu this cycle (recorded if a rotation)
//   undo_req      : level request, undo one move
//   rewind_req    : level request, undo every stored move
//   clr_err       : clears the sticky ovf/unf flags
//   req_ack       : one-cycle pulse, cycle after a request was accepted
//   out_valid/out_ready/out_op : inverse-rotation stream to the op mux
//   done          : one-cycle pulse after the last pop of an undo/rewind
//   count         : number of stored moves, saturating 0..DEPTH
//   full, empty   : count==DEPTH / count==0
//   last_op       : most recently recorded forward op, 0 when empty
//   ovf, unf      : sticky overflow / underflow flags
// -----------------------------------------------------------------------------
module move_history #(
  parameter int DEPTH = 16,
  parameter int OPW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [OPW-1:0]           op_in,
  input  logic                     undo_req,
  input  logic                     rewind_req,
  input  logic                     clr_err,
  output logic                     req_ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPW-1:0]           out_op,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [OPW-1:0]           last_op,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Rotation op codes shared with the alu decoder.
  localparam logic [OPW-1:0] RTX0 = OPW'(4'h8);
  localparam logic [OPW-1:0] RTX2 = OPW'(4'h9);
  localparam logic [OPW-1:0] RTY0 = OPW'(4'hA);
  localparam logic [OPW-1:0] RTY2 = OPW'(4'hB);
  localparam logic [OPW-1:0] RTZ0 = OPW'(4'hC);
  localparam logic [OPW-1:0] RTZ2 = OPW'(4'hD);

  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEPTH);
  localparam logic [AW-1:0]  IDX_ONE  = AW'(1);
  localparam logic [AW-1:0]  IDX_TWO  = AW'(2);
  localparam logic [OPW-1:0] OP_ZERO  = {OPW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNDO   = 2'd1,
    ST_REWIND = 2'd2
  } state_t;

  // True for the six rotation codes; everything else is not recorded.
  function automatic logic is_rot(input logic [OPW-1:0] op);
    case (op)
      RTX0, RTX2, RTY0, RTY2, RTZ0, RTZ2: is_rot = 1'b1;
      default:                            is_rot = 1'b0;
    endcase
  endfunction

  // Fixed quarter-turn inverse map; non-rotations map to zero.
  function automatic logic [OPW-1:0] inv_op(input logic [OPW-1:0] op);
    case (op)
      RTX0:    inv_op = RTX2;
      RTX2:    inv_op = RTX0;
      RTY0:    inv_op = RTY2;
      RTY2:    inv_op = RTY0;
      RTZ0:    inv_op = RTZ2;
      RTZ2:    inv_op = RTZ0;
      default: inv_op = OP_ZERO;
    endcase
  endfunction

  // Registered state and outputs
  state_t            state_r;
  logic [OPW-1:0]    stack_r [DEPTH];
  logic [CW-1:0]     count_r;
  logic              full_r;
  logic              empty_r;
  logic [OPW-1:0]    last_op_r;
  logic              out_valid_r;
  logic [OPW-1:0]    out_op_r;
  logic              req_ack_r;
  logic              done_r;
  logic              ovf_r;
  logic              unf_r;

  // Next-state values
  state_t            state_s;
  logic [CW-1:0]     count_s;
  logic [OPW-1:0]    last_op_s;
  logic              out_valid_s;
  logic [OPW-1:0]    out_op_s;
  logic              req_ack_s;
  logic              done_s;
  logic              ovf_s;
  logic              unf_s;
  logic              push_s;
  logic              pop_s;
  logic              hs_s;

  // Stack indices derived from the count. The low AW bits wrap correctly
  // even at count==DEPTH, and are only used when the stack is non-empty
  // (top) or holds at least two entries (below top).
  logic [AW-1:0]     wr_idx_s;
  logic [AW-1:0]     top_idx_s;
  logic [AW-1:0]     sub_idx_s;

  assign wr_idx_s  = count_r[AW-1:0];
  assign top_idx_s = count_r[AW-1:0] - IDX_ONE;
  assign sub_idx_s = count_r[AW-1:0] - IDX_TWO;
  assign hs_s      = out_valid_r & out_ready;

  // Sequencer next-state: push/request arbitration, pops, flags
  always_comb begin
    state_s     = state_r;
    out_valid_s = out_valid_r;
    out_op_s    = out_op_r;
    req_ack_s   = 1'b0;
    done_s      = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    // clear first so that a same-cycle error event below overrides it
    ovf_s       = clr_err ? 1'b0 : ovf_r;
    unf_s       = clr_err ? 1'b0 : unf_r;

    case (state_r)
      ST_IDLE: begin
        if (push) begin
          // push blocks requests this cycle, even for non-rotation ops
          if (is_rot(op_in)) begin
            if (full_r) begin
              ovf_s = 1'b1;
            end else begin
              push_s = 1'b1;
            end
          end else begin
            push_s = 1'b0;
          end
        end else if (rewind_req) begin
          req_ack_s = 1'b1;
          if (empty_r) begin
            done_s = 1'b1;
          end else begin
            state_s     = ST_REWIND;
            out_valid_s = 1'b1;
            out_op_s    = stack_r[top_idx_s];
          end
        end else if (undo_req) begin
          req_ack_s = 1'b1;
          if (empty_r) begin
            unf_s = 1'b1;
          end else begin
            state_s     = ST_UNDO;
            out_valid_s = 1'b1;
            out_op_s    = stack_r[top_idx_s];
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_UNDO: begin
        if (hs_s) begin
          pop_s       = 1'b1;
          done_s      = 1'b1;
          state_s     = ST_IDLE;
          out_valid_s = 1'b0;
          out_op_s    = OP_ZERO;
        end else begin
          state_s = ST_UNDO;
        end
      end

      ST_REWIND: begin
        if (hs_s) begin
          pop_s = 1'b1;
          if (count_r == CNT_ONE) begin
            done_s      = 1'b1;
            state_s     = ST_IDLE;
            out_valid_s = 1'b0;
            out_op_s    = OP_ZERO;
          end else begin
            // present the entry below the one just popped next cycle
            out_op_s = stack_r[sub_idx_s];
          end
        end else begin
          state_s = ST_REWIND;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        out_valid_s = 1'b0;
        out_op_s    = OP_ZERO;
      end
    endcase
  end

  // Count and top-of-stack view follow the push/pop decision
  always_comb begin
    count_s   = count_r;
    last_op_s = last_op_r;
    if (push_s) begin
      count_s   = count_r + CNT_ONE;
      last_op_s = op_in;
    end else if (pop_s) begin
      count_s = count_r - CNT_ONE;
      if (count_r > CNT_ONE) begin
        last_op_s = inv_op(stack_r[sub_idx_s]);
      end else begin
        last_op_s = OP_ZERO;
      end
    end else begin
      count_s   = count_r;
      last_op_s = last_op_r;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      count_r     <= {CW{1'b0}};
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      last_op_r   <= OP_ZERO;
      out_valid_r <= 1'b0;
      out_op_r    <= OP_ZERO;
      req_ack_r   <= 1'b0;
      done_r      <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      full_r      <= (count_s == CNT_MAX);
      empty_r     <= (count_s == {CW{1'b0}});
      last_op_r   <= last_op_s;
      out_valid_r <= out_valid_s;
      out_op_r    <= out_op_s;
      req_ack_r   <= req_ack_s;
      done_r      <= done_s;
      ovf_r       <= ovf_s;
      unf_r       <= unf_s;
    end
  end

  // Stack storage: each entry holds the inverse of the recorded rotation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= OP_ZERO;
      end
    end else if (push_s) begin
      stack_r[wr_idx_s] <= inv_op(op_in);
    end else begin
      stack_r[wr_idx_s] <= stack_r[wr_idx_s];
    end
  end

  assign req_ack   = req_ack_r;
  assign out_valid = out_valid_r;
  assign out_op    = out_op_r;
  assign done      = done_r;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign last_op   = last_op_r;
  assign ovf       = ovf_r;
  assign unf       = unf_r;

endmodule
